ldm_stm_sequencer: RTL and testbench

LDM_STM_SEQUENCER -- requirements
Module: ldm_stm_sequencer

---
 rtl/ldm_stm_pkg.sv | 26 ++
 rtl/lowest_set_bit.sv | 19 +
 rtl/ldm_stm_sequencer.sv | 200 ++++++++++++++++++++
 tb/tb_ldm_stm_sequencer.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ldm_stm_pkg.sv
// Shared definitions for the LDM/STM block-transfer sequencer: state encoding,
// word size and register-count width.
package ldm_stm_pkg;

   localparam int unsigned WORD_BYTES = 4;
   // Enough bits to count all 16 registers.
   localparam int unsigned CNT_W = 5;

   typedef enum logic [2:0] {
      StIdle,
      StFetch,
      StXfer,
      StWb,
      StDone
   } state_e;

   function automatic logic [CNT_W-1:0] popcount16(input logic [15:0] v);
      logic [CNT_W-1:0] c;
      c = '0;
      for (int i = 0; i < 16; i++) begin
         c = c + CNT_W'(v[i]);
      end
      return c;
   endfunction

endpackage

// File: rtl/lowest_set_bit.sv
// Combinational 16-bit find-first-set: index of the lowest set bit plus a valid flag.
module lowest_set_bit (
   input  logic [15:0] vec,
   output logic [3:0]  idx,
   output logic        valid
);

   always_comb begin
      idx   = 4'd0;
      valid = |vec;
      // Scan downward so the lowest set bit is the last one to win.
      for (int i = 15; i >= 0; i--) begin
         if (vec[i]) begin
            idx = 4'(i);
         end
      end
   end

endmodule

// File: rtl/ldm_stm_sequencer.sv
// Block load/store multiple sequencer: walks a 16-bit register list, moving one
// word per FETCH/XFER pair between the register file and memory.
module ldm_stm_sequencer
   import ldm_stm_pkg::*;
#(
   parameter int unsigned N = 32
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         start,
   input  logic         is_load,
   input  logic         up,
   input  logic         pre,
   input  logic         writeback,
   input  logic [3:0]   base_reg,
   input  logic [N-1:0] base_addr,
   input  logic [15:0]  reg_list,
   output logic         busy,
   output logic         done,
   output logic [3:0]   rf_read_addr,
   input  logic [N-1:0] rf_read_data,
   output logic         rf_write_en,
   output logic [3:0]   rf_write_addr,
   output logic [N-1:0] rf_write_data,
   output logic         mem_req,
   output logic         mem_we,
   output logic [N-1:0] mem_addr,
   output logic [N-1:0] mem_wdata,
   input  logic         mem_ack,
   input  logic [N-1:0] mem_rdata
);

   localparam logic [N-1:0] STEP = N'(WORD_BYTES);

   state_e       state_q, state_d;
   logic         is_load_q, is_load_d;
   logic         wb_q, wb_d;
   logic         base_in_list_q, base_in_list_d;
   logic [3:0]   base_reg_q, base_reg_d;
   logic [15:0]  remaining_q, remaining_d;
   logic [N-1:0] addr_q, addr_d;
   logic [N-1:0] final_q, final_d;
   logic [3:0]   cur_idx_q, cur_idx_d;
   logic [N-1:0] wdata_q, wdata_d;
   logic         xfer_first_q, xfer_first_d;
   logic         wr_en_q, wr_en_d;
   logic [3:0]   wr_addr_q, wr_addr_d;
   logic [N-1:0] wr_data_q, wr_data_d;

   logic [CNT_W-1:0] n_regs;
   logic [N-1:0]     span;
   logic [N-1:0]     first_addr;
   logic [N-1:0]     final_base;
   logic [3:0]       lsb_idx;
   logic             lsb_valid;
   logic [15:0]      rem_clr;

   lowest_set_bit u_lsb (
      .vec   (remaining_q),
      .idx   (lsb_idx),
      .valid (lsb_valid)
   );

   assign n_regs     = popcount16(reg_list);
   assign span       = N'(n_regs) * STEP;
   assign final_base = up ? (base_addr + span) : (base_addr - span);
   assign rem_clr    = remaining_q & ~(16'd1 << cur_idx_q);

   always_comb begin
      case ({up, pre})
         2'b10:   first_addr = base_addr;
         2'b11:   first_addr = base_addr + STEP;
         2'b00:   first_addr = base_addr - span + STEP;
         default: first_addr = base_addr - span;
      endcase
   end

   always_comb begin
      state_d        = state_q;
      is_load_d      = is_load_q;
      wb_d           = wb_q;
      base_in_list_d = base_in_list_q;
      base_reg_d     = base_reg_q;
      remaining_d    = remaining_q;
      addr_d         = addr_q;
      final_d        = final_q;
      cur_idx_d      = cur_idx_q;
      wdata_d        = wdata_q;
      xfer_first_d   = 1'b0;
      wr_en_d        = 1'b0;
      wr_addr_d      = '0;
      wr_data_d      = '0;

      unique case (state_q)
         StIdle: begin
            if (start) begin
               is_load_d      = is_load;
               wb_d           = writeback;
               base_reg_d     = base_reg;
               base_in_list_d = reg_list[base_reg];
               remaining_d    = reg_list;
               addr_d         = first_addr;
               final_d        = final_base;
               state_d        = (n_regs == '0) ? StWb : StFetch;
            end
         end
         StFetch: begin
            cur_idx_d    = lsb_idx;
            xfer_first_d = 1'b1;
            state_d      = lsb_valid ? StXfer : StWb;
         end
         StXfer: begin
            // Read data arrives one cycle after FETCH; hold a copy for wait states.
            if (xfer_first_q) begin
               wdata_d = rf_read_data;
            end
            if (mem_ack) begin
               remaining_d = rem_clr;
               addr_d      = addr_q + STEP;
               if (is_load_q) begin
                  wr_en_d   = 1'b1;
                  wr_addr_d = cur_idx_q;
                  wr_data_d = mem_rdata;
               end
               state_d = (rem_clr == '0) ? StWb : StFetch;
            end
         end
         StWb: begin
            // Registered strobe lands one cycle after any final load write.
            if (wb_q && !(is_load_q && base_in_list_q)) begin
               wr_en_d   = 1'b1;
               wr_addr_d = base_reg_q;
               wr_data_d = final_q;
            end
            state_d = StDone;
         end
         StDone: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q        <= StIdle;
         is_load_q      <= 1'b0;
         wb_q           <= 1'b0;
         base_in_list_q <= 1'b0;
         base_reg_q     <= '0;
         remaining_q    <= '0;
         addr_q         <= '0;
         final_q        <= '0;
         cur_idx_q      <= '0;
         wdata_q        <= '0;
         xfer_first_q   <= 1'b0;
         wr_en_q        <= 1'b0;
         wr_addr_q      <= '0;
         wr_data_q      <= '0;
      end else begin
         state_q        <= state_d;
         is_load_q      <= is_load_d;
         wb_q           <= wb_d;
         base_in_list_q <= base_in_list_d;
         base_reg_q     <= base_reg_d;
         remaining_q    <= remaining_d;
         addr_q         <= addr_d;
         final_q        <= final_d;
         cur_idx_q      <= cur_idx_d;
         wdata_q        <= wdata_d;
         xfer_first_q   <= xfer_first_d;
         wr_en_q        <= wr_en_d;
         wr_addr_q      <= wr_addr_d;
         wr_data_q      <= wr_data_d;
      end
   end

   assign busy      = (state_q == StFetch) || (state_q == StXfer) || (state_q == StWb);
   assign done      = (state_q == StDone);
   assign mem_req   = (state_q == StXfer);
   assign mem_we    = mem_req && !is_load_q;
   assign mem_addr  = mem_req ? {addr_q[N-1:2], 2'b00} : '0;
   assign mem_wdata = mem_we ? (xfer_first_q ? rf_read_data : wdata_q) : '0;

   assign rf_write_en   = wr_en_q;
   assign rf_write_addr = wr_addr_q;
   assign rf_write_data = wr_data_q;

   always_comb begin
      rf_read_addr = 4'd0;
      if (state_q == StFetch) begin
         rf_read_addr = lsb_idx;
      end else if (state_q == StXfer) begin
         rf_read_addr = cur_idx_q;
      end
   end

endmodule

// File: tb/tb_ldm_stm_sequencer.sv
// Directed bench for ldm_stm_sequencer with a register-file model and a memory
// responder that acks after a programmable number of wait cycles.
module tb_ldm_stm_sequencer;

   logic        clk;
   logic        rst_n;
   logic        start, is_load, up, pre, writeback;
   logic [3:0]  base_reg;
   logic [31:0] base_addr;
   logic [15:0] reg_list;
   logic        busy, done;
   logic [3:0]  rf_read_addr;
   logic [31:0] rf_read_data;
   logic        rf_write_en;
   logic [3:0]  rf_write_addr;
   logic [31:0] rf_write_data;
   logic        mem_req, mem_we;
   logic [31:0] mem_addr, mem_wdata;
   logic        mem_ack;
   logic [31:0] mem_rdata;

   ldm_stm_sequencer #(.N(32)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .start         (start),
      .is_load       (is_load),
      .up            (up),
      .pre           (pre),
      .writeback     (writeback),
      .base_reg      (base_reg),
      .base_addr     (base_addr),
      .reg_list      (reg_list),
      .busy          (busy),
      .done          (done),
      .rf_read_addr  (rf_read_addr),
      .rf_read_data  (rf_read_data),
      .rf_write_en   (rf_write_en),
      .rf_write_addr (rf_write_addr),
      .rf_write_data (rf_write_data),
      .mem_req       (mem_req),
      .mem_we        (mem_we),
      .mem_addr      (mem_addr),
      .mem_wdata     (mem_wdata),
      .mem_ack       (mem_ack),
      .mem_rdata     (mem_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Responder/model state, written only by the responder process.
   logic [31:0] regs [16];
   bit          regs_init = 1'b0;
   logic [31:0] acc_addr_l [16];
   logic [31:0] acc_data_l [16];
   logic        acc_we_l   [16];
   logic [3:0]  wr_addr_l  [16];
   logic [31:0] wr_data_l  [16];
   int          n_acc, n_wr, req_cycles, stab_err, wait_cnt;
   logic        prev_req, prev_we;
   logic [31:0] prev_addr, prev_wdata;
   bit          clr_seen = 1'b0;

   // Written only by the stimulus process.
   bit clr_req = 1'b0;
   int ack_delay = 0;

   always @(posedge clk) rf_read_data <= regs[rf_read_addr];

   always @(negedge clk) begin
      if (!regs_init) begin
         for (int i = 0; i < 16; i++) regs[i] = 32'h1111_0000 | 32'(i);
         regs_init = 1'b1;
      end
      if (clr_req != clr_seen) begin
         clr_seen = clr_req;
         n_acc = 0; n_wr = 0; req_cycles = 0; stab_err = 0; wait_cnt = 0;
         prev_req = 1'b0;
         for (int i = 0; i < 16; i++) begin
            acc_addr_l[i] = 'x; acc_data_l[i] = 'x; acc_we_l[i] = 1'bx;
            wr_addr_l[i] = 'x; wr_data_l[i] = 'x;
         end
      end
      if (rf_write_en) begin
         if (n_wr < 16) begin
            wr_addr_l[n_wr] = rf_write_addr;
            wr_data_l[n_wr] = rf_write_data;
         end
         n_wr++;
         regs[rf_write_addr] = rf_write_data;
      end
      if (mem_req) begin
         req_cycles++;
         if (prev_req && (mem_addr !== prev_addr || mem_we !== prev_we ||
                          mem_wdata !== prev_wdata)) stab_err++;
         if (wait_cnt == ack_delay) begin
            mem_ack   = 1'b1;
            mem_rdata = mem_addr ^ 32'hDEAD_0000;
            if (n_acc < 16) begin
               acc_addr_l[n_acc] = mem_addr;
               acc_data_l[n_acc] = mem_wdata;
               acc_we_l[n_acc]   = mem_we;
            end
            n_acc++;
            wait_cnt = 0;
         end else begin
            mem_ack = 1'b0;
            wait_cnt++;
         end
      end else begin
         mem_ack   = 1'b0;
         mem_rdata = '0;
         wait_cnt  = 0;
      end
      prev_req   = mem_req && !mem_ack;
      prev_addr  = mem_addr;
      prev_we    = mem_we;
      prev_wdata = mem_wdata;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic chk_acc(input string tag, input int i, input logic we,
                          input logic [31:0] a, input logic [31:0] d);
      check($sformatf("%s_acc%0d_we", tag, i), 32'(acc_we_l[i]), 32'(we));
      check($sformatf("%s_acc%0d_addr", tag, i), acc_addr_l[i], a);
      if (we) check($sformatf("%s_acc%0d_data", tag, i), acc_data_l[i], d);
   endtask

   task automatic chk_wr(input string tag, input int i, input logic [3:0] a,
                         input logic [31:0] d);
      check($sformatf("%s_wr%0d_addr", tag, i), 32'(wr_addr_l[i]), 32'(a));
      check($sformatf("%s_wr%0d_data", tag, i), wr_data_l[i], d);
   endtask

   task automatic clear_logs();
      clr_req = ~clr_req;
      @(negedge clk);
   endtask

   // One transfer; inputs are scrambled after the start cycle and a stray start is
   // offered mid-run and in the DONE cycle, all of which must be ignored.
   task automatic run(input string tag, input logic ld, input logic u, input logic p,
                      input logic w, input logic [3:0] br, input logic [31:0] base,
                      input logic [15:0] list, input int dly, output int cyc);
      ack_delay = dly;
      clear_logs();
      is_load = ld; up = u; pre = p; writeback = w;
      base_reg = br; base_addr = base; reg_list = list; start = 1'b1;
      cyc = 0;
      while (cyc < 200) begin
         @(negedge clk);
         cyc++;
         start     = (cyc == 3);
         is_load   = ~ld; up = ~u; pre = ~p; writeback = ~w;
         reg_list  = 16'hFFFF;
         base_addr = 32'hBAD0_0000;
         base_reg  = 4'hE;
         if (cyc == 1) check({tag, "_busy"}, 32'(busy), 32'd1);
         if (done) break;
      end
      check({tag, "_done_seen"}, 32'(done), 32'd1);
      check({tag, "_done_busy"}, 32'(busy), 32'd0);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check({tag, "_idle_after_done"}, 32'({busy, done, mem_req}), 32'd0);
   endtask

   int cyc;

   initial begin
      rst_n = 1'b0; start = 1'b0; is_load = 1'b0; up = 1'b0; pre = 1'b0;
      writeback = 1'b0; base_reg = '0; base_addr = '0; reg_list = '0;
      mem_ack = 1'b0; mem_rdata = '0;
      repeat (2) @(negedge clk);
      check("reset_ctrl", 32'({busy, done, mem_req, mem_we, rf_write_en}), 32'd0);
      check("reset_mem_addr", mem_addr, 32'd0);
      check("reset_rf_addrs", 32'({rf_read_addr, rf_write_addr}), 32'd0);
      check("reset_data", mem_wdata | rf_write_data, 32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      // STM R1,R2 ascending, post-increment, writeback to R13.
      run("stm_up", 1'b0, 1'b1, 1'b0, 1'b1, 4'd13, 32'h1000, 16'h0006, 0, cyc);
      check("stm_up_cycles", 32'(cyc), 32'd6);
      check("stm_up_nacc", 32'(n_acc), 32'd2);
      chk_acc("stm_up", 0, 1'b1, 32'h1000, 32'h1111_0001);
      chk_acc("stm_up", 1, 1'b1, 32'h1004, 32'h1111_0002);
      check("stm_up_nwr", 32'(n_wr), 32'd1);
      chk_wr("stm_up", 0, 4'd13, 32'h1008);

      // LDM R0,R15 descending, pre-decrement, writeback to R3.
      run("ldm_dn", 1'b1, 1'b0, 1'b1, 1'b1, 4'd3, 32'h2000, 16'h8001, 0, cyc);
      check("ldm_dn_cycles", 32'(cyc), 32'd6);
      check("ldm_dn_nacc", 32'(n_acc), 32'd2);
      chk_acc("ldm_dn", 0, 1'b0, 32'h1FF8, 32'h0);
      chk_acc("ldm_dn", 1, 1'b0, 32'h1FFC, 32'h0);
      check("ldm_dn_nwr", 32'(n_wr), 32'd3);
      chk_wr("ldm_dn", 0, 4'd0, 32'hDEAD_1FF8);
      chk_wr("ldm_dn", 1, 4'd15, 32'hDEAD_1FFC);
      chk_wr("ldm_dn", 2, 4'd3, 32'h1FF8);

      // LDM of the base register itself with 3 wait states: load wins.
      run("ldm_wait", 1'b1, 1'b1, 1'b0, 1'b1, 4'd4, 32'h3000, 16'h0010, 3, cyc);
      check("ldm_wait_cycles", 32'(cyc), 32'd7);
      check("ldm_wait_req_cycles", 32'(req_cycles), 32'd4);
      check("ldm_wait_stable", 32'(stab_err), 32'd0);
      chk_acc("ldm_wait", 0, 1'b0, 32'h3000, 32'h0);
      check("ldm_wait_nwr", 32'(n_wr), 32'd1);
      chk_wr("ldm_wait", 0, 4'd4, 32'hDEAD_3000);

      // Empty list: no memory traffic, base rewritten unchanged.
      run("empty", 1'b0, 1'b1, 1'b0, 1'b1, 4'd7, 32'h4000, 16'h0000, 0, cyc);
      check("empty_cycles", 32'(cyc), 32'd2);
      check("empty_req_cycles", 32'(req_cycles), 32'd0);
      check("empty_nwr", 32'(n_wr), 32'd1);
      chk_wr("empty", 0, 4'd7, 32'h4000);

      // Address wrap at the top of the address space, no writeback.
      run("wrap", 1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 32'hFFFF_FFFC, 16'h0003, 0, cyc);
      check("wrap_nacc", 32'(n_acc), 32'd2);
      chk_acc("wrap", 0, 1'b1, 32'hFFFF_FFFC, 32'hDEAD_1FF8);
      chk_acc("wrap", 1, 1'b1, 32'h0000_0000, 32'h1111_0001);
      check("wrap_nwr", 32'(n_wr), 32'd0);

      // STM R4-R7 descending, post-decrement, one wait state each.
      run("stm_dn", 1'b0, 1'b0, 1'b0, 1'b1, 4'd2, 32'h5000, 16'h00F0, 1, cyc);
      check("stm_dn_cycles", 32'(cyc), 32'd14);
      check("stm_dn_stable", 32'(stab_err), 32'd0);
      chk_acc("stm_dn", 0, 1'b1, 32'h4FF4, 32'hDEAD_3000);
      chk_acc("stm_dn", 1, 1'b1, 32'h4FF8, 32'h1111_0005);
      chk_acc("stm_dn", 2, 1'b1, 32'h4FFC, 32'h1111_0006);
      chk_acc("stm_dn", 3, 1'b1, 32'h5000, 32'h4000);
      check("stm_dn_nwr", 32'(n_wr), 32'd1);
      chk_wr("stm_dn", 0, 4'd2, 32'h4FF0);

      // Reset during XFER of a 4-register STM, with ack pending.
      ack_delay = 1;
      clear_logs();
      is_load = 1'b0; up = 1'b1; pre = 1'b0; writeback = 1'b1;
      base_reg = 4'd9; base_addr = 32'h6000; reg_list = 16'h0F00; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int k = 0; k < 20 && !mem_req; k++) @(negedge clk);
      check("rst_req_seen", 32'(mem_req), 32'd1);
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("rst_async_req", 32'({mem_req, busy, rf_write_en}), 32'd0);
      check("rst_async_addr", mem_addr, 32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      check("rst_no_writes", 32'(n_wr), 32'd0);
      check("rst_idle", 32'({busy, done, mem_req}), 32'd0);

      // Normal LDM after the aborted transfer, ascending pre-increment.
      run("after_rst", 1'b1, 1'b1, 1'b1, 1'b0, 4'd0, 32'h7000, 16'h0002, 0, cyc);
      check("after_rst_cycles", 32'(cyc), 32'd4);
      chk_acc("after_rst", 0, 1'b0, 32'h7004, 32'h0);
      check("after_rst_nwr", 32'(n_wr), 32'd1);
      chk_wr("after_rst", 0, 4'd1, 32'hDEAD_7004);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
